rr_slice_scheduler: RTL
=======================

// Module: rr_slice_scheduler
// PURPOSE
//  Synthesizable round-robin time-slice scheduler for the process/resource model.
//  It holds a remaining-work counter per process and grants one shared execution
//  resource, one process at a time, for at most QUANTUM cycles per slice.
//  Unfinished processes rotate to the back of the order; finished processes raise done.
//  Sits between the work-load front end and the shared resource's grant/enable inputs.
// PARAMETERS
//  NUM_PROC  5  number of processes/requesters (>=2)
//  QUANTUM   3  max cycles per slice (>=1)
//  BURST_W   8  width of burst (work) counters, in cycles
// PORTS
//  clk          in   1                      clock, rising edge
//  rst_n        in   1                      async active-low reset
//  en           in   1                      scheduler enable; gates new slice starts
//  load_valid   in   1                      load work for process load_id
//  load_id      in   $clog2(NUM_PROC)       process index
//  load_burst   in   BURST_W                work cycles to load
//  load_ready   out  1                      comb: load_id valid and not active
//  grant        out  NUM_PROC               one-hot, resource owner this cycle
//  grant_valid  out  1                      =|grant
//  slice_end    out  1                      pulse on last cycle of a slice
//  done         out  NUM_PROC               sticky per-process completion
//  all_done     out  1                      &done
// BEHAVIOUR
//  Reset: remaining=0, active=0, done=0, ptr=0, qcnt=0, state=IDLE;
//   grant=0, grant_valid=0, slice_end=0, all_done=0.
//  Load (load_valid&&load_ready): remaining[id]<=burst, done[id]<=0, active[id]<=1.
//   burst==0: done[id]<=1, active stays 0.
//   load_id>=NUM_PROC or active[id]: load_ready=0, no effect.
//   A process going inactive in the same cycle is still active, so load_ready=0.
//  FSM IDLE/PICK/RUN:
//   IDLE: go to PICK when en && |active.
//   PICK (1 cycle, grant=0): cur <= first active index searching ptr, ptr+1, ..
//    modulo NUM_PROC; qcnt<=0; go to RUN.
//    No active, or en=0: go to IDLE.
//   RUN: grant=onehot(cur); each cycle remaining[cur]--, qcnt++.
//    Last cycle of the slice is when remaining[cur]==1 or qcnt==QUANTUM-1.
//    On that cycle: slice_end=1; next cycle ptr=(cur+1)%NUM_PROC, state=PICK.
//    If remaining hit 0: active[cur]=0 and done[cur]=1, visible the cycle after slice_end.
//  A sole active process is re-picked after a 1-cycle PICK bubble.
//  en deassert during RUN: the current slice completes; no new slice starts.
//  Loads during RUN for other ids are accepted and join the rotation at the next PICK.
//  Async reset mid-slice: everything returns to reset values immediately,
//   with no slice_end and no done.
//  Counters never underflow; remaining is only decremented while granted and nonzero.
// CONFIGURATION
//  RR_STATS_EN defined: adds output switch_cnt [15:0].
//   Increments on every slice_end, saturates at 16'hFFFF, and resets to 0.
//   Loading work does not clear it.
//  RR_STATS_EN undefined: the port and its counter are absent; behaviour is otherwise identical.
// TESTING
//  1. Reset, en=0; load P0..P4 bursts 8,9,11,5,4 one per cycle; then en=1, Q=3.
//     -> Slices run P0,P1,P2,P3,P4, P0,P1,P2,P3(2),P4(1), P0(2),P1,P2, P2(2).
//     -> Completion order P3,P4,P0,P1,P2; all_done 51 cycles after en (37 work + 14 PICK).
//  2. Only P2 loaded, burst 7.
//     -> Grant slices of 3,3,1, each preceded by a PICK bubble.
//     -> done[2] rises the cycle after the third slice_end.
//  3. Load to an active id, and to id=NUM_PROC.
//     -> load_ready=0, state unchanged; a burst of 0 sets done immediately.
//  4. During P0's slice, load P3 with burst 2 while P1 is active.
//     -> Order continues P1 then P3 (ptr rotation); P3 finishes after one 2-cycle slice.
//  5. Assert rst_n=0 mid-slice.
//     -> grant, done and slice_end go to 0 asynchronously; after release the block stays IDLE until a reload.
//  6. RR_STATS_EN, scenario 1.
//     -> switch_cnt==14 at all_done.

Source files
------------

// File: rtl/rr_slice_scheduler.sv
// Round-robin time-slice scheduler: per-process work counters, one shared resource granted
// for at most QUANTUM cycles per slice. Optional RR_STATS_EN adds a saturating switch_cnt.
module rr_slice_scheduler #(
    parameter int NUM_PROC = 5,
    parameter int QUANTUM  = 3,
    parameter int BURST_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        load_valid,
    input  logic [$clog2(NUM_PROC)-1:0] load_id,
    input  logic [BURST_W-1:0]          load_burst,
    output logic                        load_ready,
    output logic [NUM_PROC-1:0]         grant,
    output logic                        grant_valid,
    output logic                        slice_end,
    output logic [NUM_PROC-1:0]         done,
`ifdef RR_STATS_EN
    output logic [15:0]                 switch_cnt,
`endif
    output logic                        all_done
);

    localparam int ID_W = $clog2(NUM_PROC);
    localparam int QW   = $clog2(QUANTUM + 1);

    typedef enum logic [1:0] {IDLE, PICK, RUN} state_t;

    state_t                           state, state_next;
    logic [ID_W-1:0]                  cur, cur_next, ptr, ptr_next;
    logic [QW-1:0]                    qcnt, qcnt_next;
    logic [NUM_PROC-1:0][BURST_W-1:0] remaining;
    logic [NUM_PROC-1:0]              active;
    logic [(2**ID_W)-1:0]             active_ext;
    logic                             load_fire, last_cycle, pick_found;
    logic [ID_W-1:0]                  pick_idx;
    logic [ID_W:0]                    cand;
    logic [BURST_W-1:0]               rem_cur;

    // Zero-padded copy so an out-of-range load_id indexes a defined bit.
    assign active_ext  = (2**ID_W)'(active);
    assign load_ready  = ({1'b0, load_id} < (ID_W+1)'(NUM_PROC)) && !active_ext[load_id];
    assign load_fire   = load_valid && load_ready;
    assign rem_cur     = remaining[cur];
    assign last_cycle  = (rem_cur <= BURST_W'(1)) || (qcnt == QW'(QUANTUM - 1));
    assign grant_valid = |grant;
    assign all_done    = &done;

    // First active index at or after ptr, wrapping; lowest offset wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_PROC))
                cand = cand - (ID_W+1)'(NUM_PROC);
            if (active_ext[cand[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        cur_next   = cur;
        ptr_next   = ptr;
        qcnt_next  = qcnt;
        grant      = '0;
        slice_end  = 1'b0;
        case (state)
            IDLE: begin
                if (en && |active)
                    state_next = PICK;
            end
            PICK: begin
                if (en && pick_found) begin
                    cur_next   = pick_idx;
                    qcnt_next  = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                grant     = NUM_PROC'(1) << cur;
                qcnt_next = qcnt + QW'(1);
                if (last_cycle) begin
                    slice_end  = 1'b1;
                    qcnt_next  = '0;
                    ptr_next   = (cur == ID_W'(NUM_PROC - 1)) ? '0 : cur + ID_W'(1);
                    state_next = PICK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= '0;
            ptr   <= '0;
            qcnt  <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
            ptr   <= ptr_next;
            qcnt  <= qcnt_next;
        end
    end

    // Per-process work counter; load and decrement never coincide since loads need !active.
    for (genvar p = 0; p < NUM_PROC; p++) begin : g_proc
        logic [BURST_W-1:0] rem_q;
        logic               act_q, done_q;
        logic               is_load, is_dec;

        assign is_load = load_fire && (load_id == ID_W'(p));
        assign is_dec  = (state == RUN) && (cur == ID_W'(p)) && (rem_q != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rem_q  <= '0;
                act_q  <= 1'b0;
                done_q <= 1'b0;
            end else if (is_load) begin
                rem_q  <= load_burst;
                act_q  <= |load_burst;
                done_q <= ~|load_burst;
            end else if (is_dec) begin
                rem_q <= rem_q - BURST_W'(1);
                if (rem_q == BURST_W'(1)) begin
                    act_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end

        assign remaining[p] = rem_q;
        assign active[p]    = act_q;
        assign done[p]      = done_q;
    end

`ifdef RR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            switch_cnt <= '0;
        else if (slice_end && switch_cnt != 16'hFFFF)
            switch_cnt <= switch_cnt + 16'd1;
    end
`endif

endmodule
